// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant and per-owner burst hold.
// Optional RR_LOCK_EN adds a lock input that lets the owner extend its burst.
module rr_arbiter_n #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
`ifdef RR_LOCK_EN
    input  logic             lock,
`endif
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             owner_req;
    logic             lock_hold;

    // Rotating search starting just after the last winner, wrapping at N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            int p;
            p = (int'(last_q) + i) % N;
            if (!win_found && req[p]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(p);
            end
        end
    end

    assign owner_req = req[idx_q];

`ifdef RR_LOCK_EN
    assign lock_hold = owner_req & lock;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = OWN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    valid_d          = 1'b1;
                    idx_d            = win_idx;
                    last_d           = win_idx;
                    hold_d           = CNT_W'(1);
                end
            end
            OWN: begin
                if (lock_hold) begin
                    // Locked burst: keep grant, counter saturates at the cap.
                    if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + CNT_W'(1);
                    end else begin
                        hold_d = HOLD_MAX;
                    end
                end else if (owner_req && hold_q < HOLD_MAX) begin
                    hold_d = hold_q + CNT_W'(1);
                end else if (win_found) begin
                    // Owner is last_q, so the search already starts at owner+1.
                    state_d          = OWN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    valid_d          = 1'b1;
                    idx_d            = win_idx;
                    last_d           = win_idx;
                    hold_d           = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= PTR_INIT;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

endmodule
